// File: rtl/uart_tx_frame.sv
// UART frame serialiser: start, D0..D7 LSB first, parity, stop.
// Define UART_TX_STOP2_EN to append a second stop bit (frame = 12 bit times).
module uart_tx_frame #(
  parameter int CLK_HZ = 50_000_000,
  parameter int CNT_W  = 17
) (
  input  logic       CLK_50M,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [2:0] bps_sel,
  input  logic       check_sel,
  output logic       TX,
  output logic       busy,
  output logic       tx_done
);

  localparam logic [CNT_W-1:0] DIV_600   = CNT_W'((CLK_HZ + 300) / 600);
  localparam logic [CNT_W-1:0] DIV_1200  = CNT_W'((CLK_HZ + 600) / 1200);
  localparam logic [CNT_W-1:0] DIV_2400  = CNT_W'((CLK_HZ + 1200) / 2400);
  localparam logic [CNT_W-1:0] DIV_4800  = CNT_W'((CLK_HZ + 2400) / 4800);
  localparam logic [CNT_W-1:0] DIV_9600  = CNT_W'((CLK_HZ + 4800) / 9600);
  localparam logic [CNT_W-1:0] DIV_19200 = CNT_W'((CLK_HZ + 9600) / 19200);
  localparam logic [CNT_W-1:0] DIV_38400 = CNT_W'((CLK_HZ + 19200) / 38400);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
`ifdef UART_TX_STOP2_EN
    , S_STOP2
`endif
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] baud_cnt;
  logic [CNT_W-1:0] div_m1;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;
  logic [7:0]       data;
  logic             odd;
  logic             bit_end;
  logic [CNT_W-1:0] div_sel;

  always_comb begin
    div_sel = DIV_9600;
    case (bps_sel)
      3'd0:    div_sel = DIV_600;
      3'd1:    div_sel = DIV_1200;
      3'd2:    div_sel = DIV_2400;
      3'd3:    div_sel = DIV_4800;
      3'd4:    div_sel = DIV_9600;
      3'd5:    div_sel = DIV_19200;
      3'd6:    div_sel = DIV_38400;
      default: div_sel = DIV_9600;
    endcase
  end

  assign bit_end = (baud_cnt == div_m1);
  assign busy    = ~tx_ready;

  // TX is registered from the current state, so the line lags the state by one
  // clock: accept at edge N puts the start bit on the line from edge N+1.
  always_ff @(posedge CLK_50M or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      div_m1   <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      data     <= '0;
      odd      <= 1'b0;
      TX       <= 1'b1;
      tx_ready <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (state == S_IDLE || bit_end) baud_cnt <= '0;
      else                            baud_cnt <= baud_cnt + CNT_ONE;
      case (state)
        S_IDLE: begin
          TX <= 1'b1;
          if (tx_valid && tx_ready) begin
            shift    <= tx_data;
            data     <= tx_data;
            odd      <= check_sel;
            div_m1   <= div_sel - CNT_ONE;
            tx_ready <= 1'b0;
            state    <= S_START;
          end else begin
            tx_ready <= 1'b1;
          end
        end
        S_START: begin
          TX <= 1'b0;
          if (bit_end) begin
            bit_cnt <= '0;
            state   <= S_DATA;
          end
        end
        S_DATA: begin
          TX <= shift[0];
          if (bit_end) begin
            shift <= shift >> 1;
            if (bit_cnt == 3'd7) state <= S_PARITY;
            else                 bit_cnt <= bit_cnt + 3'd1;
          end
        end
        S_PARITY: begin
          TX <= odd ? ~^data : ^data;
          if (bit_end) state <= S_STOP;
        end
        S_STOP: begin
          TX <= 1'b1;
          if (bit_end) begin
`ifdef UART_TX_STOP2_EN
            state   <= S_STOP2;
`else
            state   <= S_IDLE;
            tx_done <= 1'b1;
`endif
          end
        end
`ifdef UART_TX_STOP2_EN
        S_STOP2: begin
          TX <= 1'b1;
          if (bit_end) begin
            state   <= S_IDLE;
            tx_done <= 1'b1;
          end
        end
`endif
        default: begin
          TX    <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
